dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Arbiter and sequencer for the single-ported data memory behind the pipeline's MEM stage. It shares the memory between the pipeline (load/store in MEM) and a debug/loader port, drives a variable-latency req/ready memory handshake, and generates `stall_M` to freeze the pipeline registers while a pipeline access is outstanding. It sits between the EX/MEM register outputs and the data memory, and feeds read data to the MEM/WB register.

## Interface
- `TIMEOUT`, 255: maximum cycles a transaction may wait for `mem_ready` before it is aborted; must be ≥1.
- `clk  in  1`: clock, rising edge.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `pipe_req_M  in  1`: MEM-stage instruction is a load or store.
- `pipe_we_M  in  1`: 1 = store.
- `pipe_addr_M  in  32`: ALU result in MEM, used as the byte address.
- `pipe_wdata_M  in  32`: store data.
- `pipe_rdata_M  out  32`: load data to MEM/WB.
- `stall_M  out  1`: freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB.
- `dbg_req  in  1`, `dbg_we  in  1`, `dbg_addr  in  32`, `dbg_wdata  in  32`: debug request; held stable until `dbg_gnt`.
- `dbg_gnt  out  1`: one-cycle acceptance pulse.
- `dbg_rvalid  out  1`, `dbg_rdata  out  32`: one-cycle completion pulse with read data.
- `mem_req  out  1`, `mem_we  out  1`, `mem_addr  out  32`, `mem_wdata  out  32`: memory request.
- `mem_ready  in  1`, `mem_rdata  in  32`: memory completion; data is valid in the same cycle as `mem_ready`.
- `err_timeout  out  1`: sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY_P, BUSY_D.
- IDLE:
  - Only `pipe_req_M` → BUSY_P.
  - Only `dbg_req` → BUSY_D and pulse `dbg_gnt` in this cycle.
  - Both → round-robin on the registered `last_grant`. Reset value is DEBUG, so the pipeline wins the first tie.
- On grant, latch we/addr/wdata into the request registers. `mem_*` outputs are driven only from these registers.
  - `mem_req` = 1 exactly while state is BUSY_P or BUSY_D.
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable for the whole BUSY state.
- BUSY_x with `mem_ready` = 1 → IDLE and update `last_grant`.
  - BUSY_P: `pipe_rdata_M` = `mem_rdata`, passed through combinationally in that cycle.
  - BUSY_D: `dbg_rdata` is registered from `mem_rdata` and `dbg_rvalid` pulses in the following cycle.
- `stall_M` = `pipe_req_M` AND NOT (state == BUSY_P AND (`mem_ready` OR timeout)). The pipeline stalls in IDLE, in BUSY_D, and during BUSY_P wait states.
  - The stall releases in the completion cycle, so the pipeline advances at that edge.
  - The next cycle is therefore IDLE with a new MEM instruction, and the same access is never reissued.
- `pipe_rdata_M` = 0 when not completing. Store completions return no data.
- Timeout:
  - `wait_cnt` has width clog2(`TIMEOUT`+1). It clears on entry to BUSY and increments each BUSY cycle with `mem_ready` = 0.
  - When `wait_cnt` == `TIMEOUT`-1 and `mem_ready` = 0, abort: treat the cycle as completion with read data 0 and set `err_timeout`.
  - `err_timeout` is cleared only by reset.
- A `dbg_req` arriving during BUSY_P waits; it is not lost.
- A `pipe_req_M` arriving during BUSY_D stalls until debug completes.

## Timing
- Reset values: state IDLE; `mem_req`/`mem_we` 0; `mem_addr`/`mem_wdata` 0; `stall_M` = `pipe_req_M` (combinational); `pipe_rdata_M` 0; `dbg_gnt`/`dbg_rvalid` 0; `dbg_rdata` 0; `err_timeout` 0; `last_grant` DEBUG.
- Reset asserted mid-transaction drops `mem_req` immediately without waiting for a clock. The memory must tolerate the abandoned request.
- Pipeline access latency is 1 + N cycles, where N ≥ 1 is the number of BUSY cycles up to and including the `mem_ready` cycle. Minimum stall is 1 cycle (IDLE) plus N-1 wait cycles, so a zero-wait memory stalls exactly 1 cycle.
- Debug transaction: `dbg_gnt` at cycle t, `mem_req` from t+1, `mem_ready` at t+k, `dbg_rvalid` at t+k+1.
- `dbg_gnt` and `dbg_rvalid` are never high in the same cycle as each other for one transaction. A new debug grant occurs only from IDLE.

## Test plan
- Load from 0x100, memory returns 0xDEADBEEF with `mem_ready` in the first BUSY cycle → `stall_M` high 1 cycle; `mem_req` high 1 cycle; `pipe_rdata_M` = 0xDEADBEEF when `stall_M` falls.
- Store 0x12345678 to 0x200 with 3 wait states → `mem_we` = 1; addr/data stable for 4 BUSY cycles; `stall_M` high 4 cycles; no second `mem_req`.
- `pipe_req_M` and `dbg_req` held continuously from reset → grants alternate pipe, dbg, pipe, dbg; each `dbg_gnt` is followed by `dbg_rvalid` with the correct read data.
- `TIMEOUT` = 8, `mem_ready` held 0 on a pipeline load → abort after 8 BUSY cycles; `err_timeout` = 1 and stays 1; `pipe_rdata_M` = 0; stall released.
- `reset_n` dropped during the 2nd wait state of a BUSY_D transaction → `mem_req`, `dbg_gnt` and `dbg_rvalid` go to 0 immediately; state IDLE; no `dbg_rvalid` after reset releases.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one req/ready memory between the MEM-stage
// pipeline access and a debug/loader port, stalls the pipeline while its
// access is outstanding, and aborts accesses that wait too long.
module dmem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    // Pipeline MEM stage
    input  logic        pipe_req_M,
    input  logic        pipe_we_M,
    input  logic [31:0] pipe_addr_M,
    input  logic [31:0] pipe_wdata_M,
    output logic [31:0] pipe_rdata_M,
    output logic        stall_M,

    // Debug / loader port
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,

    // Memory handshake
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        err_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusyP,
        StBusyD
    } state_e;

    typedef enum logic {
        GntPipe,
        GntDbg
    } grant_e;

    state_e          r_state;
    grant_e          r_last_grant;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [CntW-1:0] r_wait_cnt;
    logic            r_dbg_rvalid;
    logic [31:0]     r_dbg_rdata;
    logic            r_err_timeout;

    logic            w_busy;
    logic            w_timeout;
    logic            w_done;
    logic            w_pick_pipe;
    logic            w_pick_dbg;
    logic [31:0]     w_ret_data;

    // Arbitration, completion/abort detection and returned read data
    always_comb begin
        w_busy      = (r_state != StIdle);
        w_timeout   = w_busy && !mem_ready && (r_wait_cnt == CntLast);
        w_done      = w_busy && (mem_ready || w_timeout);
        // Round-robin on a tie: whoever did not win last time goes first
        w_pick_pipe = pipe_req_M && (!dbg_req || (r_last_grant == GntDbg));
        w_pick_dbg  = dbg_req && !w_pick_pipe;
        // Aborts and store completions return zero
        w_ret_data  = (mem_ready && !r_we) ? mem_rdata : 32'h0;
    end

    // Output drive; mem_* comes only from the request registers
    always_comb begin
        mem_req      = w_busy;
        mem_we       = r_we;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        pipe_rdata_M = (r_state == StBusyP) ? w_ret_data : 32'h0;
        stall_M      = pipe_req_M && !((r_state == StBusyP) && w_done);
        // Gated by reset so the grant cannot pulse while the block is held in reset
        dbg_gnt      = reset_n && (r_state == StIdle) && w_pick_dbg;
        dbg_rvalid   = r_dbg_rvalid;
        dbg_rdata    = r_dbg_rdata;
        err_timeout  = r_err_timeout;
    end

    // Sequencer FSM with request latching, wait counter and debug response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_last_grant  <= GntDbg;
            r_we          <= 1'b0;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_wait_cnt    <= '0;
            r_dbg_rvalid  <= 1'b0;
            r_dbg_rdata   <= 32'h0;
            r_err_timeout <= 1'b0;
        end else begin
            r_dbg_rvalid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_pipe) begin
                        r_state    <= StBusyP;
                        r_we       <= pipe_we_M;
                        r_addr     <= pipe_addr_M;
                        r_wdata    <= pipe_wdata_M;
                        r_wait_cnt <= '0;
                    end else if (w_pick_dbg) begin
                        r_state    <= StBusyD;
                        r_we       <= dbg_we;
                        r_addr     <= dbg_addr;
                        r_wdata    <= dbg_wdata;
                        r_wait_cnt <= '0;
                    end
                end
                StBusyP, StBusyD: begin
                    if (w_done) begin
                        r_state      <= StIdle;
                        r_last_grant <= (r_state == StBusyD) ? GntDbg : GntPipe;
                        if (r_state == StBusyD) begin
                            r_dbg_rvalid <= 1'b1;
                            r_dbg_rdata  <= w_ret_data;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_err_timeout <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
